uart_rx: RTL and testbench

//   Parametrised UART receiver. Oversamples a serial line and majority-votes each bit.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_fifo.sv | 54 +++++
 rtl/uart_rx.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_ODD  = 2'd1,
      PAR_EVEN = 2'd2
   } parity_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_HIGH
   } rx_state_t;

   // 2-of-3 majority of three line samples.
   function automatic logic maj3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small first-word-fall-through FIFO for received frames.
// Latency: a push is visible at the head on the cycle after the write edge.
// Backpressure: pop on valid && ready; a push into a full FIFO is taken only with a same-cycle pop.
// Ports: clock, reset (async active-low), push/push_data (write side),
//        data/valid/ready (head of FIFO), full (status for drop detection).
module uart_rx_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   input  logic             ready,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   // One extra wrap bit distinguishes full from empty when the indices match.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             pop;
   logic             wr_en;

   assign valid = (wr_ptr != rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = valid && ready;
   // When full, the slot being written is the one being popped this cycle.
   assign wr_en = push && (!full || pop);
   assign data  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with majority vote, parity/stop checking and a receive FIFO.
// Latency: a frame appears at the FIFO head one cycle after the vote of its last stop bit.
// Backpressure: head holds while !_out_ready; a frame arriving into a full FIFO is dropped and flagged by _overrun.
// Ports: _clock, _reset (async active-low), _in (raw serial line, idle high),
//        _out/_out_valid/_out_ready (head entry handshake), _parity_err/_frame_err (head entry flags),
//        _overrun (one-cycle pulse per dropped frame).
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLOCKS_PER_BIT = 8,
   parameter int DATA_BITS      = 8,
   parameter int PARITY         = 0,
   parameter int STOP_BITS      = 1,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                 _clock,
   input  logic                 _reset,
   input  logic                 _in,
   output logic [DATA_BITS-1:0] _out,
   output logic                 _out_valid,
   input  logic                 _out_ready,
   output logic                 _parity_err,
   output logic                 _frame_err,
   output logic                 _overrun
);

   localparam parity_t    PAR_MODE  = (PARITY == 1) ? PAR_ODD : (PARITY == 2) ? PAR_EVEN : PAR_NONE;
   localparam int         MID       = CLOCKS_PER_BIT / 2;
   localparam logic [7:0] TICK_LAST = 8'(CLOCKS_PER_BIT - 1);
   localparam logic [7:0] TICK_VOTE = 8'(MID + 1);
   localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
   localparam int         EW        = DATA_BITS + 2;

   logic                 sync1;
   logic                 rx;
   logic [1:0]           hist;
   logic [7:0]           tick;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_err;
   logic                 frm_err;
   rx_state_t            state;
   rx_state_t            state_nxt;

   logic                 vote_now;
   logic                 tick_wrap;
   logic                 bit_val;
   logic                 tick_run;
   logic                 frame_start;
   logic                 shift_en;
   logic                 par_cap;
   logic                 frm_set;
   logic                 bit_inc;
   logic                 bit_clr;
   logic                 push;
   logic [EW-1:0]        push_data;
   logic [EW-1:0]        head;
   logic                 full;

   // Synchroniser plus a two-deep history of rx. At the vote tick the history holds
   // the samples from ticks MID-1 and MID, and rx itself is the MID+1 sample.
   always_ff @(posedge _clock or negedge _reset) begin
      if (!_reset) begin
         sync1 <= 1'b1;
         rx    <= 1'b1;
         hist  <= 2'b11;
      end else begin
         sync1 <= _in;
         rx    <= sync1;
         hist  <= {hist[0], rx};
      end
   end

   assign tick_wrap = (tick == TICK_LAST);
   assign vote_now  = (tick == TICK_VOTE);
   assign bit_val   = maj3({hist, rx});

   always_ff @(posedge _clock or negedge _reset) begin
      if (!_reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      frame_start = 1'b0;
      shift_en    = 1'b0;
      par_cap     = 1'b0;
      frm_set     = 1'b0;
      bit_inc     = 1'b0;
      bit_clr     = 1'b0;
      push        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!rx) begin
               state_nxt   = ST_START;
               frame_start = 1'b1;
            end
         end
         ST_START: begin
            if (vote_now && bit_val) begin
               state_nxt = ST_IDLE;
            end else if (tick_wrap) begin
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            shift_en = vote_now;
            if (tick_wrap) begin
               if (bit_cnt == DATA_LAST) begin
                  bit_clr   = 1'b1;
                  state_nxt = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_inc = 1'b1;
               end
            end
         end
         ST_PARITY: begin
            par_cap = vote_now;
            if (tick_wrap) begin
               state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            frm_set = vote_now && !bit_val;
            // The last stop bit ends the frame at its vote, not at the end of the bit.
            if (vote_now && (bit_cnt == STOP_LAST)) begin
               push      = 1'b1;
               state_nxt = bit_val ? ST_IDLE : ST_WAIT_HIGH;
            end else if (tick_wrap) begin
               bit_inc = 1'b1;
            end
         end
         ST_WAIT_HIGH: begin
            if (rx) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      tick_run = (state != ST_IDLE) && (state != ST_WAIT_HIGH) &&
                 (state_nxt != ST_IDLE) && (state_nxt != ST_WAIT_HIGH);
   end

   always_ff @(posedge _clock or negedge _reset) begin
      if (!_reset) begin
         tick    <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         par_err <= 1'b0;
         frm_err <= 1'b0;
      end else begin
         if (!tick_run || tick_wrap) begin
            tick <= '0;
         end else begin
            tick <= tick + 8'd1;
         end
         if (frame_start || bit_clr) begin
            bit_cnt <= '0;
         end else if (bit_inc) begin
            bit_cnt <= bit_cnt + 4'd1;
         end
         // LSB arrives first, so shift in at the top and right-shift.
         if (shift_en) begin
            shreg <= {bit_val, shreg[DATA_BITS-1:1]};
         end
         if (frame_start) begin
            par_err <= 1'b0;
            frm_err <= 1'b0;
         end else begin
            if (par_cap) begin
               par_err <= ((^shreg) ^ bit_val) != (PAR_MODE == PAR_ODD);
            end
            if (frm_set) begin
               frm_err <= 1'b1;
            end
         end
      end
   end

   // The last stop vote is folded in directly since frm_err only updates on the push edge.
   assign push_data = {frm_err | !bit_val, par_err, shreg};

   uart_rx_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (_clock),
      .reset     (_reset),
      .push      (push),
      .push_data (push_data),
      .data      (head),
      .valid     (_out_valid),
      .ready     (_out_ready),
      .full      (full)
   );

   assign _out        = head[DATA_BITS-1:0];
   assign _parity_err = head[DATA_BITS];
   assign _frame_err  = head[DATA_BITS+1];

   always_ff @(posedge _clock or negedge _reset) begin
      if (!_reset) begin
         _overrun <= 1'b0;
      end else begin
         _overrun <= push && full && !(_out_valid && _out_ready);
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 (depth 4), 8E1 and 9N2 instances on separate lines.
// Frames are driven bit-accurately at 8 clocks per bit; popped entries are logged per instance.
module tb_uart_rx;

   localparam int CPB = 8;

   logic       clk;
   logic       rst_n;
   logic       in_a, in_p, in_9;
   logic       ready_a, ready_p, ready_9;
   logic [7:0] out_a, out_p;
   logic [8:0] out_9;
   logic       valid_a, valid_p, valid_9;
   logic       pe_a, pe_p, pe_9;
   logic       fe_a, fe_p, fe_9;
   logic       ovr_a, ovr_p, ovr_9;

   int checks;
   int errors;

   logic [10:0] cap_a [64];
   logic [10:0] cap_p [64];
   logic [10:0] cap_9 [64];
   int wa, wp, w9;
   int ra, rp, r9;
   int ovr_cnt;

   typedef struct {
      int         sel;
      logic [8:0] data;
      logic       pbit;
      logic       sval;
      logic [8:0] exp_data;
      logic       exp_pe;
      logic       exp_fe;
   } vec_t;

   vec_t vecs[10];

   uart_rx #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
      ._clock(clk), ._reset(rst_n), ._in(in_a), ._out(out_a), ._out_valid(valid_a),
      ._out_ready(ready_a), ._parity_err(pe_a), ._frame_err(fe_a), ._overrun(ovr_a));

   uart_rx #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_p (
      ._clock(clk), ._reset(rst_n), ._in(in_p), ._out(out_p), ._out_valid(valid_p),
      ._out_ready(ready_p), ._parity_err(pe_p), ._frame_err(fe_p), ._overrun(ovr_p));

   uart_rx #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_9 (
      ._clock(clk), ._reset(rst_n), ._in(in_9), ._out(out_9), ._out_valid(valid_9),
      ._out_ready(ready_9), ._parity_err(pe_9), ._frame_err(fe_9), ._overrun(ovr_9));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      wa = 0; wp = 0; w9 = 0; ovr_cnt = 0;
   end

   // Log every accepted head entry as {frame_err, parity_err, data[8:0]}.
   always @(negedge clk) begin
      if (valid_a && ready_a) begin
         cap_a[wa % 64] <= {fe_a, pe_a, 1'b0, out_a};
         wa <= wa + 1;
      end
      if (valid_p && ready_p) begin
         cap_p[wp % 64] <= {fe_p, pe_p, 1'b0, out_p};
         wp <= wp + 1;
      end
      if (valid_9 && ready_9) begin
         cap_9[w9 % 64] <= {fe_9, pe_9, out_9};
         w9 <= w9 + 1;
      end
      if (ovr_a) begin
         ovr_cnt <= ovr_cnt + 1;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input int sel, input logic v);
      case (sel)
         0:       in_a = v;
         1:       in_p = v;
         default: in_9 = v;
      endcase
      repeat (CPB) step();
   endtask

   // sel 0: 8N1, sel 1: 8E1, sel 2: 9N2. sval is the last stop bit; one idle bit follows.
   task automatic send_frame(input int sel, input logic [8:0] d, input logic pbit, input logic sval);
      int nb;
      nb = (sel == 2) ? 9 : 8;
      drive_bit(sel, 1'b0);
      for (int i = 0; i < nb; i++) drive_bit(sel, d[i]);
      if (sel == 1) drive_bit(sel, pbit);
      if (sel == 2) drive_bit(sel, 1'b1);
      drive_bit(sel, sval);
      drive_bit(sel, 1'b1);
   endtask

   // Returns the number of entries logged since the last call and the first of them.
   task automatic collect(input int sel, output int n, output logic [10:0] first);
      first = '0;
      case (sel)
         0: begin n = wa - ra; if (n > 0) first = cap_a[ra % 64]; ra = wa; end
         1: begin n = wp - rp; if (n > 0) first = cap_p[rp % 64]; rp = wp; end
         default: begin n = w9 - r9; if (n > 0) first = cap_9[r9 % 64]; r9 = w9; end
      endcase
   endtask

   initial begin
      int          n;
      int          lat;
      int          ovr_base;
      logic        seen;
      logic [10:0] e;

      checks = 0; errors = 0;
      ra = 0; rp = 0; r9 = 0;

      vecs[0] = '{0, 9'h0A5, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b0};
      vecs[1] = '{0, 9'h000, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0};
      vecs[2] = '{0, 9'h0FF, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b0};
      vecs[3] = '{0, 9'h03C, 1'b0, 1'b0, 9'h03C, 1'b0, 1'b1};
      vecs[4] = '{1, 9'h003, 1'b1, 1'b1, 9'h003, 1'b1, 1'b0};
      vecs[5] = '{1, 9'h003, 1'b0, 1'b1, 9'h003, 1'b0, 1'b0};
      vecs[6] = '{1, 9'h080, 1'b1, 1'b1, 9'h080, 1'b0, 1'b0};
      vecs[7] = '{1, 9'h080, 1'b0, 1'b1, 9'h080, 1'b1, 1'b0};
      vecs[8] = '{2, 9'h1FF, 1'b0, 1'b1, 9'h1FF, 1'b0, 1'b0};
      vecs[9] = '{2, 9'h155, 1'b0, 1'b0, 9'h155, 1'b0, 1'b1};

      rst_n = 1'b0;
      in_a = 1'b1; in_p = 1'b1; in_9 = 1'b1;
      ready_a = 1'b1; ready_p = 1'b1; ready_9 = 1'b1;
      repeat (4) step();
      check("rst_valid", valid_a, 0);
      check("rst_out", out_a, 0);
      check("rst_parity_err", pe_a, 0);
      check("rst_frame_err", fe_a, 0);
      check("rst_overrun", ovr_a, 0);
      rst_n = 1'b1;
      repeat (4) step();

      // Valid must rise exactly one cycle after the stop-bit vote: 81 edges from the start edge.
      seen = 1'b0;
      lat  = 0;
      fork
         send_frame(0, 9'h0A5, 1'b0, 1'b1);
         begin
            while (!seen && lat < 200) begin
               step();
               lat++;
               if (valid_a) seen = 1'b1;
            end
            check("lat_8n1_valid_edge", lat, 81);
         end
      join
      collect(0, n, e);
      check("lat_8n1_count", n, 1);
      check("lat_8n1_data", e[8:0], 9'h0A5);
      check("lat_8n1_flags", e[10:9], 2'b00);

      for (int i = 0; i < 10; i++) begin
         collect(vecs[i].sel, n, e);
         send_frame(vecs[i].sel, vecs[i].data, vecs[i].pbit, vecs[i].sval);
         collect(vecs[i].sel, n, e);
         check($sformatf("vec%0d_count", i), n, 1);
         check($sformatf("vec%0d_data", i), e[8:0], vecs[i].exp_data);
         check($sformatf("vec%0d_parity_err", i), e[9], vecs[i].exp_pe);
         check($sformatf("vec%0d_frame_err", i), e[10], vecs[i].exp_fe);
      end

      // Two-clock low glitch: rejected at the start-bit vote.
      collect(0, n, e);
      in_a = 1'b0;
      repeat (2) step();
      in_a = 1'b1;
      repeat (8) step();
      check("glitch_fsm_idle", dut_a.state == uart_pkg::ST_IDLE, 1);
      repeat (16) step();
      collect(0, n, e);
      check("glitch_no_entry", n, 0);

      // Break: stop bit low and the line held low for 40 more bits.
      for (int i = 0; i < 10; i++) drive_bit(0, 1'b0);
      for (int i = 0; i < 40; i++) drive_bit(0, 1'b0);
      drive_bit(0, 1'b1);
      drive_bit(0, 1'b1);
      collect(0, n, e);
      check("break_count", n, 1);
      check("break_data", e[8:0], 9'h000);
      check("break_frame_err", e[10], 1);
      send_frame(0, 9'h05A, 1'b0, 1'b1);
      collect(0, n, e);
      check("after_break_count", n, 1);
      check("after_break_data", e[8:0], 9'h05A);
      check("after_break_flags", e[10:9], 2'b00);

      // Overrun: four frames fill the FIFO, the fifth is dropped.
      ready_a  = 1'b0;
      ovr_base = ovr_cnt;
      for (int k = 0; k < 4; k++) send_frame(0, 9'h011 + 9'(k), 1'b0, 1'b1);
      check("ovr_none_yet", ovr_cnt - ovr_base, 0);
      check("ovr_full_valid", valid_a, 1);
      check("ovr_head_hold", out_a, 8'h11);
      send_frame(0, 9'h015, 1'b0, 1'b1);
      check("ovr_one_pulse", ovr_cnt - ovr_base, 1);
      check("ovr_head_after_drop", out_a, 8'h11);
      ready_a = 1'b1;
      repeat (10) step();
      check("ovr_drain_count", wa - ra, 4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("ovr_drain%0d", k), cap_a[(ra + k) % 64], {3'b000, 8'h11 + 8'(k)});
      end
      ra = wa;
      check("ovr_drained_empty", valid_a, 0);

      // Reset in the middle of the data bits of 0x3C discards that frame.
      drive_bit(0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(0, ((i == 2) || (i == 3)) ? 1'b1 : 1'b0);
      rst_n = 1'b0;
      in_a  = 1'b1;
      repeat (3) step();
      check("midrst_valid", valid_a, 0);
      rst_n = 1'b1;
      drive_bit(0, 1'b1);
      drive_bit(0, 1'b1);
      send_frame(0, 9'h0C3, 1'b0, 1'b1);
      drive_bit(0, 1'b1);
      collect(0, n, e);
      check("midrst_count", n, 1);
      check("midrst_data", e[8:0], 9'h0C3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
